// File: rtl/pcpi_arb_pkg.sv
// Shared types and instruction decode for the PCPI multiplier arbiter.
// Arbitration mode is selected by the PCPI_ARB_RR_EN macro (see pcpi_mul_arbiter).
package pcpi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP,
        COOL
    } state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    // funct7 and opcode must match exactly; only funct3[2] matters (0 = multiply family)
    localparam logic [31:0] MUL_MASK  = {7'h7F, 5'd0, 5'd0, 3'b100, 5'd0, 7'h7F};
    localparam logic [31:0] MUL_MATCH = {F7_MULDIV, 5'd0, 5'd0, 3'b000, 5'd0, OPC_OP};

    function automatic logic is_mul(input logic [31:0] insn);
        return (insn & MUL_MASK) == MUL_MATCH;
    endfunction

endpackage

// File: rtl/pcpi_arb_picker.sv
// Combinational winner selection: first eligible requester at or after the pointer.
// With a pointer of zero this reduces to fixed priority, requester 0 highest.
module pcpi_arb_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        int j;
        logic [IDX_W-1:0] jj;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        jj  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            jj = IDX_W'(j);
            if (!any && elig[jj]) begin
                any     = 1'b1;
                gnt[jj] = 1'b1;
                idx     = jj;
            end
        end
    end

endmodule

// File: rtl/pcpi_mul_arbiter.sv
// Shares one PCPI multiplier between NUM_REQ PCPI requesters.
// Define PCPI_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (requester 0 first).
module pcpi_mul_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_insn,
    input  logic [NUM_REQ*32-1:0] req_rs1,
    input  logic [NUM_REQ*32-1:0] req_rs2,
    output logic [NUM_REQ-1:0]    resp_wr,
    output logic [31:0]           resp_rd,
    output logic [NUM_REQ-1:0]    resp_wait,
    output logic [NUM_REQ-1:0]    resp_ready,
    output logic                  mul_valid,
    output logic [31:0]           mul_insn,
    output logic [31:0]           mul_rs1,
    output logic [31:0]           mul_rs2,
    input  logic                  mul_wr,
    input  logic [31:0]           mul_rd,
    input  logic                  mul_ready
);

    import pcpi_arb_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [IDX_W-1:0]   ptr;
    logic [31:0]        sel_insn, sel_rs1, sel_rs2;
    logic [NUM_REQ-1:0] gnt_oh;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [31:0]        insn_q, insn_d;
    logic [31:0]        rs1_q, rs1_d;
    logic [31:0]        rs2_q, rs2_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mul_valid_q, mul_valid_d;
    logic [NUM_REQ-1:0] resp_ready_q, resp_ready_d;
    logic [NUM_REQ-1:0] resp_wr_q, resp_wr_d;
    logic [31:0]        rd_q, rd_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i] && is_mul(req_insn[32*i +: 32]);
        end
    end

`ifdef PCPI_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    pcpi_arb_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .elig (elig),
        .ptr  (ptr),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Operand mux driven directly by the one-hot winner
    always_comb begin
        sel_insn = '0;
        sel_rs1  = '0;
        sel_rs2  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_insn = sel_insn | ({32{pick_gnt[i]}} & req_insn[32*i +: 32]);
            sel_rs1  = sel_rs1  | ({32{pick_gnt[i]}} & req_rs1[32*i +: 32]);
            sel_rs2  = sel_rs2  | ({32{pick_gnt[i]}} & req_rs2[32*i +: 32]);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_oh[i] = (gidx_q == IDX_W'(i));
        end
    end

    always_comb begin
        state_d      = state_q;
        gidx_d       = gidx_q;
        insn_d       = insn_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        cnt_d        = cnt_q;
        mul_valid_d  = mul_valid_q;
        resp_ready_d = '0;
        resp_wr_d    = '0;
        rd_d         = rd_q;
`ifdef PCPI_ARB_RR_EN
        ptr_d        = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d     = ISSUE;
                    gidx_d      = pick_idx;
                    insn_d      = sel_insn;
                    rs1_d       = sel_rs1;
                    rs2_d       = sel_rs2;
                    cnt_d       = '0;
                    mul_valid_d = 1'b1;
`ifdef PCPI_ARB_RR_EN
                    ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
`endif
                end
            end
            ISSUE: begin
                if (mul_ready) begin
                    state_d      = RESP;
                    mul_valid_d  = 1'b0;
                    rd_d         = mul_rd;
                    resp_ready_d = gnt_oh;
                    resp_wr_d    = gnt_oh & {NUM_REQ{mul_wr}};
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Multiplier never answered: abandon the grant silently
                    state_d     = COOL;
                    mul_valid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = COOL;
            end
            COOL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            gidx_q       <= '0;
            insn_q       <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            cnt_q        <= '0;
            mul_valid_q  <= 1'b0;
            resp_ready_q <= '0;
            resp_wr_q    <= '0;
            rd_q         <= '0;
`ifdef PCPI_ARB_RR_EN
            ptr_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            gidx_q       <= gidx_d;
            insn_q       <= insn_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            cnt_q        <= cnt_d;
            mul_valid_q  <= mul_valid_d;
            resp_ready_q <= resp_ready_d;
            resp_wr_q    <= resp_wr_d;
            rd_q         <= rd_d;
`ifdef PCPI_ARB_RR_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

    assign mul_valid  = mul_valid_q;
    assign mul_insn   = insn_q;
    assign mul_rs1    = rs1_q;
    assign mul_rs2    = rs2_q;
    assign resp_ready = resp_ready_q;
    assign resp_wr    = resp_wr_q;
    assign resp_rd    = rd_q;

    // Keeps pending requesters from hitting their own PCPI timeout; forced low while in reset
    assign resp_wait  = elig & ~resp_ready_q & {NUM_REQ{resetn}};

endmodule

// File: tb/tb_pcpi_mul_arbiter.sv
// Directed, table-driven bench for pcpi_mul_arbiter with a behavioural multiplier.
module tb_pcpi_mul_arbiter;

    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [NR-1:0]     req_valid;
    logic [NR*32-1:0]  req_insn, req_rs1, req_rs2;
    logic [NR-1:0]     resp_wr, resp_wait, resp_ready;
    logic [31:0]       resp_rd;
    logic              mul_valid;
    logic [31:0]       mul_insn, mul_rs1, mul_rs2;
    logic              mul_wr, mul_ready;
    logic [31:0]       mul_rd;
    logic              mul_en;
    int                mcnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pcpi_mul_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_insn   (req_insn),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .resp_wr    (resp_wr),
        .resp_rd    (resp_rd),
        .resp_wait  (resp_wait),
        .resp_ready (resp_ready),
        .mul_valid  (mul_valid),
        .mul_insn   (mul_insn),
        .mul_rs1    (mul_rs1),
        .mul_rs2    (mul_rs2),
        .mul_wr     (mul_wr),
        .mul_rd     (mul_rd),
        .mul_ready  (mul_ready)
    );

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    function automatic logic [31:0] mul_ref(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        logic [1:0]  f;
        f  = insn[13:12];
        ea = (f == 2'd1 || f == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (f == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (f == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Behavioural multiplier: answers 2 cycles after mul_valid rises, unless disabled
    always @(posedge clk) begin
        if (!resetn) begin
            mul_ready <= 1'b0;
            mul_wr    <= 1'b0;
            mul_rd    <= 32'd0;
            mcnt      <= 0;
        end else begin
            mul_ready <= 1'b0;
            mul_wr    <= 1'b0;
            if (mul_valid && !mul_ready && mul_en) begin
                if (mcnt == 1) begin
                    mul_ready <= 1'b1;
                    mul_wr    <= 1'b1;
                    mul_rd    <= mul_ref(mul_insn, mul_rs1, mul_rs2);
                    mcnt      <= 0;
                end else begin
                    mcnt <= mcnt + 1;
                end
            end else begin
                mcnt <= 0;
            end
        end
    end

    typedef struct {
        int          req;
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        elig;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input logic v, input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
        req_valid[r]          = v;
        req_insn[32*r +: 32]  = insn;
        req_rs1[32*r +: 32]   = a;
        req_rs2[32*r +: 32]   = b;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int seen;
        logic [NR-1:0] oh;
        oh = NR'(1 << v.req);
        drive(v.req, 1'b1, v.insn, v.rs1, v.rs2);
        #1;
        chk("wait_pending", 32'(resp_wait[v.req]), 32'(v.elig));
        step();
        if (v.elig) begin
            chk("issue_latency", 32'(mul_valid), 32'd1);
            chk("mul_insn", mul_insn, v.insn);
            chk("mul_rs1", mul_rs1, v.rs1);
            chk("mul_rs2", mul_rs2, v.rs2);
            n = 0;
            while (resp_ready == '0 && n < 30) begin
                step();
                n++;
            end
            if (resp_ready == '0) begin
                checks++;
                errors++;
                $display("FAIL resp_timeout: got no resp_ready after %0d cycles, required one", n);
            end else begin
                chk("resp_latency", 32'(n), 32'd3);
                chk("resp_ready", 32'(resp_ready), 32'(oh));
                chk("resp_wr", 32'(resp_wr), 32'(oh));
                chk("resp_rd", resp_rd, v.exp_rd);
                chk("wait_in_resp", 32'(resp_wait[v.req]), 32'd0);
                req_valid[v.req] = 1'b0;
                step();
                chk("ready_one_cycle", 32'(resp_ready), 32'd0);
                chk("cool_mul_valid", 32'(mul_valid), 32'd0);
                chk("rd_held", resp_rd, v.exp_rd);
                step();
            end
        end else begin
            seen = 0;
            for (int c = 0; c < 5; c++) begin
                if (mul_valid || resp_ready != '0 || resp_wait != '0 || resp_wr != '0) seen++;
                step();
            end
            chk("inelig_quiet", 32'(seen), 32'd0);
            req_valid[v.req] = 1'b0;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_g[3];
        int n;
        int w;
        int rdy_seen;
        logic [31:0] ins_mul;

        req_valid = '0;
        req_insn  = '0;
        req_rs1   = '0;
        req_rs2   = '0;
        mul_en    = 1'b1;
        ins_mul   = mk(7'b0000001, 3'd0, 7'b0110011);

        tbl[0] = '{0, ins_mul,                            32'd7,        32'd6,        1'b1, 32'd42};
        tbl[1] = '{1, mk(7'b0000001, 3'd3, 7'b0110011),   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE};
        tbl[2] = '{0, mk(7'b0000001, 3'd1, 7'b0110011),   32'hFFFFFFFE, 32'd3,        1'b1, 32'hFFFFFFFF};
        tbl[3] = '{1, mk(7'b0000001, 3'd2, 7'b0110011),   32'h80000000, 32'd4,        1'b1, 32'hFFFFFFFE};
        tbl[4] = '{0, mk(7'b0000001, 3'd3, 7'b0110011),   32'h80000000, 32'd4,        1'b1, 32'd2};
        tbl[5] = '{0, mk(7'b0000000, 3'd0, 7'b0110011),   32'd7,        32'd6,        1'b0, 32'd0};
        tbl[6] = '{1, mk(7'b0000001, 3'd4, 7'b0110011),   32'd7,        32'd6,        1'b0, 32'd0};
        tbl[7] = '{0, mk(7'b0000001, 3'd0, 7'b0010011),   32'd7,        32'd6,        1'b0, 32'd0};

        // Reset state
        step();
        step();
        chk("rst_outputs", {31'd0, mul_valid} | mul_insn | mul_rs1 | mul_rs2 | resp_rd, 32'd0);
        chk("rst_resp", 32'({resp_ready, resp_wr, resp_wait}), 32'd0);
        resetn = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i]);
        end

        // Multiplier never answers: grant abandoned after the timeout
        mul_en = 1'b0;
        drive(0, 1'b1, ins_mul, 32'd7, 32'd6);
        step();
        n = 0;
        rdy_seen = 0;
        while (mul_valid && n < 40) begin
            n++;
            if (resp_ready != '0) rdy_seen++;
            step();
        end
        chk("timeout_len", 32'(n), 32'd16);
        if (resp_ready != '0) rdy_seen++;
        chk("timeout_no_ready", 32'(rdy_seen), 32'd0);
        req_valid[0] = 1'b0;
        step();
        mul_en = 1'b1;
        run_vec(tbl[0]);

        // Reset asserted while the multiplier is busy
        drive(0, 1'b1, ins_mul, 32'd9, 32'd9);
        step();
        chk("pre_rst_issue", 32'(mul_valid), 32'd1);
        resetn = 1'b0;
        #1;
        chk("async_rst_mul", {31'd0, mul_valid} | mul_insn | mul_rs1 | mul_rs2, 32'd0);
        chk("async_rst_rd", resp_rd, 32'd0);
        chk("async_rst_resp", 32'({resp_ready, resp_wr, resp_wait}), 32'd0);
        step();
        step();
        req_valid = '0;
        resetn = 1'b1;
        step();
        chk("post_rst_idle", 32'({mul_valid, resp_ready}), 32'd0);
        run_vec(tbl[1]);

        // Two simultaneous requesters, three rounds, from a fresh pointer
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();
`ifdef PCPI_ARB_RR_EN
        exp_g = '{0, 1, 0};
`else
        exp_g = '{0, 0, 0};
`endif
        drive(0, 1'b1, ins_mul, 32'd3, 32'd5);
        drive(1, 1'b1, ins_mul, 32'd4, 32'd5);
        for (int r = 0; r < 3; r++) begin
            n = 0;
            while (resp_ready == '0 && n < 40) begin
                step();
                n++;
            end
            if (resp_ready == '0) begin
                checks++;
                errors++;
                $display("FAIL arb_timeout: round %0d got no resp_ready, required one", r);
            end else begin
                w = resp_ready[1] ? 1 : 0;
                chk("arb_grant", 32'(w), 32'(exp_g[r]));
                chk("arb_onehot", 32'(resp_ready), 32'(1 << exp_g[r]));
                chk("arb_rd", resp_rd, (w == 1) ? 32'd20 : 32'd15);
                chk("loser_wait", 32'(resp_wait[1 - w]), 32'd1);
                req_valid[w] = 1'b0;
                step();
                req_valid[w] = 1'b1;
            end
        end
        req_valid = '0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
